// File: rtl/store_buf_if.sv
// store_buf_if: bundles the core store port, the load-forwarding lookup,
// the data-memory write port and the occupancy status of the store buffer.
// slave  = the store buffer itself
// master = whoever drives the core side and models the data memory
interface store_buf_if #(
  parameter int DEPTH = 4
) ();

  localparam int CW = $clog2(DEPTH) + 1;

  // core store path
  logic          st_valid;
  logic          st_ready;
  logic [31:0]   st_addr;
  logic [31:0]   st_data;

  // load forwarding lookup
  logic [31:0]   ld_addr;
  logic          ld_hit;
  logic [31:0]   ld_data;

  // data memory write port
  logic          mem_we;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wd;
  logic          mem_ready;

  // occupancy status
  logic [CW-1:0] count;
  logic          empty;
  logic          full;

  modport slave (
    input  st_valid, st_addr, st_data, ld_addr, mem_ready,
    output st_ready, ld_hit, ld_data, mem_we, mem_addr, mem_wd,
           count, empty, full
  );

  modport master (
    output st_valid, st_addr, st_data, ld_addr, mem_ready,
    input  st_ready, ld_hit, ld_data, mem_we, mem_addr, mem_wd,
           count, empty, full
  );

endinterface

// File: rtl/store_buf.sv
// store_buf: write buffer between the core store path and data memory.
// Word stores are queued in a circular FIFO and drained to memory with a
// valid/ready handshake; loads look up pending entries so they always see
// the newest stored value.
// Optional feature: define STORE_BUF_COALESCE_EN to merge a store into the
// newest pending entry when both target the same word.
module store_buf #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  store_buf_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Entry storage: word address (byte offset dropped) and data.
  logic [29:0]   entryAddr_q [DEPTH];
  logic [31:0]   entryData_q [DEPTH];

  // Circular pointers wrap naturally because DEPTH is a power of two.
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          isEmpty;
  logic          isFull;
  logic          doPop;
  logic          doPush;
  logic          doAlloc;
  logic          coalesce;
  logic          stReady;
  logic [PW-1:0] newestIdx;

  logic          fwdHit;
  logic [31:0]   fwdData;

  // Byte offsets of both addresses are irrelevant for word accesses.
  logic          unusedLowBits;
  assign unusedLowBits = ^{bus.st_addr[1:0], bus.ld_addr[1:0]};

  assign isEmpty   = (count_q == '0);
  assign isFull    = (count_q == CW'(DEPTH));
  assign doPop     = !isEmpty && bus.mem_ready;
  assign newestIdx = tail_q - PW'(1);

`ifdef STORE_BUF_COALESCE_EN
  // A store merges into the newest entry unless that entry is the only one
  // and is leaving for memory this very cycle; then it must allocate anew.
  assign coalesce = !isEmpty
                 && (entryAddr_q[newestIdx] == bus.st_addr[31:2])
                 && !(doPop && (count_q == CW'(1)));
`else
  assign coalesce = 1'b0;
`endif

  // A full buffer does not accept a new entry even if the head is popping;
  // only a merging store can get in when full.
  assign stReady = !isFull || coalesce;
  assign doPush  = bus.st_valid && stReady;
  assign doAlloc = doPush && !coalesce;

  // Next pointer and occupancy values from this cycle's push and pop.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (doPop) begin
      head_d = head_q + PW'(1);
    end
    if (doAlloc) begin
      tail_d = tail_q + PW'(1);
    end
    case ({doAlloc, doPop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset discards every pending store.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage: allocate at the tail, or overwrite the newest entry in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entryAddr_q[i] <= '0;
        entryData_q[i] <= '0;
      end
    end else if (doAlloc) begin
      entryAddr_q[tail_q] <= bus.st_addr[31:2];
      entryData_q[tail_q] <= bus.st_data;
    end else if (doPush) begin
      entryData_q[newestIdx] <= bus.st_data;
    end
  end

  // Forwarding: walk valid entries oldest to newest so the newest match wins.
  always_comb begin
    fwdHit  = 1'b0;
    fwdData = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < count_q) &&
          (entryAddr_q[head_q + PW'(k)] == bus.ld_addr[31:2])) begin
        fwdHit  = 1'b1;
        fwdData = entryData_q[head_q + PW'(k)];
      end
    end
  end

  // Memory side only ever sees registered head state, never st_* directly.
  assign bus.mem_we   = !isEmpty;
  assign bus.mem_addr = {entryAddr_q[head_q], 2'b00};
  assign bus.mem_wd   = entryData_q[head_q];

  assign bus.st_ready = stReady;
  assign bus.ld_hit   = fwdHit;
  assign bus.ld_data  = fwdData;
  assign bus.count    = count_q;
  assign bus.empty    = isEmpty;
  assign bus.full     = isFull;

endmodule

// File: tb/tb_store_buf.sv
// tb_store_buf: table-driven directed vectors, hand-written multi-cycle
// sequences and a randomized run against a queue-based reference model.
// Honours STORE_BUF_COALESCE_EN the same way as the design.
module tb_store_buf;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  store_buf_if #(.DEPTH(DEPTH)) bus ();

  store_buf #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        v;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] la;
    logic        mr;
    int          cnt;
    logic        rdy;
    logic        we;
    logic        chkMem;
    logic [31:0] ma;
    logic [31:0] wd;
    logic        hit;
    logic [31:0] ld;
  } vec_t;

  typedef struct {
    logic [29:0] a;
    logic [31:0] d;
  } ent_t;

  vec_t plan [13];
  ent_t mq [$];

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] a,
                               input logic [31:0] d, input logic [31:0] la,
                               input logic mr);
    bus.st_valid  = v;
    bus.st_addr   = a;
    bus.st_data   = d;
    bus.ld_addr   = la;
    bus.mem_ready = mr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    tick();
    tick();
    rst = 1'b0;

`ifndef STORE_BUF_COALESCE_EN
    // v, addr, data, ld_addr, mem_ready | count, st_ready, mem_we, chkMem, mem_addr, mem_wd, ld_hit, ld_data
    plan[0]  = '{1'b1, 32'h14, 32'hdeadc0de, 32'h0,  1'b0, 0, 1'b1, 1'b0, 1'b1, 32'h0,  32'h0,        1'b0, 32'h0};
    plan[1]  = '{1'b1, 32'h28, 32'hdeadbeef, 32'h0,  1'b0, 1, 1'b1, 1'b1, 1'b1, 32'h14, 32'hdeadc0de, 1'b0, 32'h0};
    plan[2]  = '{1'b1, 32'h2c, 32'hc001c0de, 32'h0,  1'b0, 2, 1'b1, 1'b1, 1'b1, 32'h14, 32'hdeadc0de, 1'b0, 32'h0};
    plan[3]  = '{1'b1, 32'h2c, 32'h0,        32'h2e, 1'b0, 3, 1'b1, 1'b1, 1'b1, 32'h14, 32'hdeadc0de, 1'b1, 32'hc001c0de};
    plan[4]  = '{1'b0, 32'h0,  32'h0,        32'h2e, 1'b0, 4, 1'b0, 1'b1, 1'b1, 32'h14, 32'hdeadc0de, 1'b1, 32'h0};
    plan[5]  = '{1'b1, 32'h40, 32'h1,        32'h30, 1'b0, 4, 1'b0, 1'b1, 1'b1, 32'h14, 32'hdeadc0de, 1'b0, 32'h0};
    plan[6]  = '{1'b0, 32'h0,  32'h0,        32'h2e, 1'b1, 4, 1'b0, 1'b1, 1'b1, 32'h14, 32'hdeadc0de, 1'b1, 32'h0};
    plan[7]  = '{1'b0, 32'h0,  32'h0,        32'h2e, 1'b1, 3, 1'b1, 1'b1, 1'b1, 32'h28, 32'hdeadbeef, 1'b1, 32'h0};
    plan[8]  = '{1'b0, 32'h0,  32'h0,        32'h2e, 1'b1, 2, 1'b1, 1'b1, 1'b1, 32'h2c, 32'hc001c0de, 1'b1, 32'h0};
    plan[9]  = '{1'b0, 32'h0,  32'h0,        32'h2e, 1'b1, 1, 1'b1, 1'b1, 1'b1, 32'h2c, 32'h0,        1'b1, 32'h0};
    plan[10] = '{1'b0, 32'h0,  32'h0,        32'h2e, 1'b1, 0, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 32'h0};
    plan[11] = '{1'b1, 32'h47, 32'h77,       32'h44, 1'b1, 0, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 32'h0};
    plan[12] = '{1'b0, 32'h0,  32'h0,        32'h44, 1'b0, 1, 1'b1, 1'b1, 1'b1, 32'h44, 32'h77,       1'b1, 32'h77};

    for (int i = 0; i < 13; i++) begin
      applyStimulus(plan[i].v, plan[i].a, plan[i].d, plan[i].la, plan[i].mr);
      #1;
      checkOutput($sformatf("row%0d count", i), 32'(bus.count), 32'(plan[i].cnt));
      checkOutput($sformatf("row%0d full", i), 32'(bus.full), 32'(plan[i].cnt == DEPTH));
      checkOutput($sformatf("row%0d empty", i), 32'(bus.empty), 32'(plan[i].cnt == 0));
      checkOutput($sformatf("row%0d st_ready", i), 32'(bus.st_ready), 32'(plan[i].rdy));
      checkOutput($sformatf("row%0d mem_we", i), 32'(bus.mem_we), 32'(plan[i].we));
      if (plan[i].chkMem) begin
        checkOutput($sformatf("row%0d mem_addr", i), bus.mem_addr, plan[i].ma);
        checkOutput($sformatf("row%0d mem_wd", i), bus.mem_wd, plan[i].wd);
      end
      checkOutput($sformatf("row%0d ld_hit", i), 32'(bus.ld_hit), 32'(plan[i].hit));
      checkOutput($sformatf("row%0d ld_data", i), bus.ld_data, plan[i].ld);
      tick();
    end
`endif

    // Back-to-back push while memory always accepts: one entry in flight.
    doReset();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 32'h100 + 32'(4 * i), 32'ha000 + 32'(i), 32'h0, 1'b1);
      #1;
      checkOutput($sformatf("stream%0d st_ready", i), 32'(bus.st_ready), 32'd1);
      checkOutput($sformatf("stream%0d count", i), 32'(bus.count), (i == 0) ? 32'd0 : 32'd1);
      checkOutput($sformatf("stream%0d mem_we", i), 32'(bus.mem_we), (i == 0) ? 32'd0 : 32'd1);
      if (i > 0) begin
        checkOutput($sformatf("stream%0d mem_addr", i), bus.mem_addr, 32'h100 + 32'(4 * (i - 1)));
        checkOutput($sformatf("stream%0d mem_wd", i), bus.mem_wd, 32'ha000 + 32'(i - 1));
      end
      tick();
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    #1;
    checkOutput("stream tail mem_addr", bus.mem_addr, 32'h11c);
    tick();
    checkOutput("stream drained mem_we", 32'(bus.mem_we), 32'd0);
    checkOutput("stream drained empty", 32'(bus.empty), 32'd1);

    // Reset with three pending stores discards them all.
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h200 + 32'(4 * i), 32'hb000 + 32'(i), 32'h0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h204, 1'b0);
    #1;
    checkOutput("prereset count", 32'(bus.count), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("postreset count", 32'(bus.count), 32'd0);
    checkOutput("postreset mem_we", 32'(bus.mem_we), 32'd0);
    checkOutput("postreset ld_hit", 32'(bus.ld_hit), 32'd0);
    checkOutput("postreset ld_data", bus.ld_data, 32'd0);
    checkOutput("postreset st_ready", 32'(bus.st_ready), 32'd1);
    checkOutput("postreset mem_addr", bus.mem_addr, 32'd0);
    checkOutput("postreset mem_wd", bus.mem_wd, 32'd0);
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("postreset%0d no write", i), 32'(bus.mem_we), 32'd0);
    end

`ifdef STORE_BUF_COALESCE_EN
    // Same-word stores merge, and a merge is accepted even when full.
    doReset();
    applyStimulus(1'b1, 32'h28, 32'h1111, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h28, 32'h2222, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h28, 1'b0);
    #1;
    checkOutput("coal count", 32'(bus.count), 32'd1);
    checkOutput("coal ld_hit", 32'(bus.ld_hit), 32'd1);
    checkOutput("coal ld_data", bus.ld_data, 32'h2222);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h30 + 32'(4 * i), 32'hc000 + 32'(i), 32'h0, 1'b0);
      tick();
    end
    applyStimulus(1'b1, 32'h38, 32'h5555, 32'h38, 1'b0);
    #1;
    checkOutput("coal full", 32'(bus.full), 32'd1);
    checkOutput("coal full st_ready", 32'(bus.st_ready), 32'd1);
    tick();
    applyStimulus(1'b1, 32'h30, 32'h6666, 32'h38, 1'b0);
    #1;
    checkOutput("coal full count", 32'(bus.count), 32'd4);
    checkOutput("coal merged data", bus.ld_data, 32'h5555);
    checkOutput("coal older st_ready", 32'(bus.st_ready), 32'd0);
    tick();
`endif

    // Randomized run against a queue-based model of pending stores.
    doReset();
    mq.delete();
    for (int c = 0; c < 400; c++) begin
      logic        v, mr, doRst, coal, expRdy, expHit;
      logic [31:0] a, d, la, expLd;
      int          size;
      v     = ($urandom_range(0, 2) != 0);
      mr    = ($urandom_range(0, 2) == 0);
      doRst = ($urandom_range(0, 63) == 0);
      a     = 32'(($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
      la    = 32'(($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
      d     = $urandom;
      applyStimulus(v, a, d, la, mr);
      rst = doRst;
      #1;
      size = mq.size();
      coal = 1'b0;
`ifdef STORE_BUF_COALESCE_EN
      coal = (size > 0) && (mq[size-1].a == a[31:2]) && !(mr && size == 1);
`endif
      expRdy = (size < DEPTH) || coal;
      expHit = 1'b0;
      expLd  = 32'h0;
      for (int k = size - 1; k >= 0; k--) begin
        if (!expHit && mq[k].a == la[31:2]) begin
          expHit = 1'b1;
          expLd  = mq[k].d;
        end
      end
      checkOutput("rand count", 32'(bus.count), 32'(size));
      checkOutput("rand st_ready", 32'(bus.st_ready), 32'(expRdy));
      checkOutput("rand mem_we", 32'(bus.mem_we), 32'(size > 0));
      if (size > 0) begin
        checkOutput("rand mem_addr", bus.mem_addr, {mq[0].a, 2'b00});
        checkOutput("rand mem_wd", bus.mem_wd, mq[0].d);
      end
      checkOutput("rand ld_hit", 32'(bus.ld_hit), 32'(expHit));
      checkOutput("rand ld_data", bus.ld_data, expLd);
      if (doRst) begin
        mq.delete();
      end else begin
        if (v && expRdy && coal) mq[size-1].d = d;
        if (size > 0 && mr) void'(mq.pop_front());
        if (v && expRdy && !coal) mq.push_back('{a[31:2], d});
      end
      tick();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
